// File: rtl/branch_redirect_pc.sv
// Fetch-stage PC unit: sequential fetch, branch/jump redirect, IF flush,
// and a parked redirect while instruction memory is not ready.
module branch_redirect_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             if_wait,
    input  logic             br_valid,
    input  logic             zero,
    input  logic [31:0]      br_target,
    input  logic             jmp_valid,
    input  logic [31:0]      jmp_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             if_flush,
    output logic             pending,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {RUN, PEND} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        req;
    logic        acc;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;
    logic        unused_tgt_lsb;

    assign req     = jmp_valid | (br_valid & zero);
    assign acc     = req & ~id_stall & ~rst;
    assign tgt_raw = jmp_valid ? jmp_target : br_target;
    assign tgt     = {tgt_raw[31:2], 2'b00};

    assign unused_tgt_lsb = ^tgt_raw[1:0];

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign if_flush  = acc;
    assign pending   = (state_q == PEND);
    assign taken_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (acc && !if_wait) begin
                    pc_d = tgt;
                end else if (acc) begin
                    tgt_d   = tgt;
                    state_d = PEND;
                end else if (!(id_stall || if_wait)) begin
                    pc_d = pc_plus4;
                end
            end
            PEND: begin
                // A fresh redirect supersedes the parked one
                if (acc && !if_wait) begin
                    pc_d    = tgt;
                    state_d = RUN;
                end else if (acc) begin
                    tgt_d = tgt;
                end else if (!if_wait) begin
                    pc_d    = tgt_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (acc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/branch_redirect_pc.md
# branch_redirect_pc

Fetch-stage program-counter unit that consumes the `zero` branch-taken flag produced by the ID-stage branch comparator and redirects instruction fetch. It holds the PC register, advances it sequentially, and applies branch and jump targets. It flushes the wrong-path instruction in IF, and parks a redirect in a pending register while instruction memory is not ready. It sits between ID-stage decode/compare and the instruction memory address port.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address loaded on reset.
- `CNT_W`, 16, width of the taken-redirect statistics counter.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_stall`  in  1  hazard unit holds IF/ID and PC; redirects are not accepted while high.
- `if_wait`  in  1  instruction memory not ready; PC must not change while high.
- `br_valid`  in  1  ID holds a conditional branch (beq/bne/bgtz/bgez).
- `zero`  in  1  branch condition true, from the ID branch comparator.
- `br_target`  in  32  branch target address.
- `jmp_valid`  in  1  ID holds an unconditional jump.
- `jmp_target`  in  32  jump target address.
- `pc`  out  32  registered fetch address.
- `pc_plus4`  out  32  combinational `pc + 4`, modulo 2^32.
- `if_flush`  out  1  combinational; squash the IF instruction into a bubble at the next edge.
- `pending`  out  1  registered; high in state PEND.
- `taken_cnt`  out  CNT_W  registered count of accepted redirects.

## Operation
- Redirect request `req = jmp_valid | (br_valid & zero)`. Target `tgt` is `jmp_target` when `jmp_valid`, otherwise `br_target`; jump wins if both are high.
- Redirect accepted `acc = req & ~id_stall`. `if_flush = acc`, and is low in all other cases, including during reset.
- Targets are word-aligned on load: `{tgt[31:2], 2'b00}`. `tgt_q` is loaded the same way.
- States:
  - RUN: sequential fetch.
  - PEND: an accepted redirect is waiting for `if_wait` to drop.
- RUN transitions, in priority order:
  - `acc & ~if_wait`: `pc <= tgt`; stay in RUN.
  - `acc & if_wait`: `tgt_q <= tgt`; `pc` holds; go to PEND.
  - `id_stall | if_wait`: `pc` holds.
  - Otherwise: `pc <= pc + 4`. Wraps from 32'hFFFF_FFFC to 0.
- PEND transitions, in priority order:
  - `acc & ~if_wait`: `pc <= tgt` (the new target overrides `tgt_q`); go to RUN.
  - `acc & if_wait`: `tgt_q <= tgt`; stay in PEND.
  - `~if_wait`: `pc <= tgt_q`; go to RUN.
  - Otherwise: hold.
- PEND never increments `pc`. `id_stall` alone never releases PEND.
- `taken_cnt` increments by 1 on every cycle with `acc`, in either state, and saturates at all ones.
- Reset values: `pc = RESET_PC`, state RUN, `pending = 0`, `tgt_q = 0`, `taken_cnt = 0`.
  - Reset has priority over every input.
  - Reset asserted during PEND discards `tgt_q`.

## Timing
- Redirect latency: `acc` in cycle N gives `pc == tgt` after edge N, when `if_wait` is low in cycle N.
- When a redirect is parked: `pc == tgt_q` after the first edge at which `if_wait` is sampled low.
- `if_flush` is valid in the same cycle as the `zero`/`br_valid` it depends on. The IF/ID register applies it at edge N.
- Exactly one wrong-path instruction is squashed per redirect; there is no delay slot.
- `pc_plus4` follows `pc` combinationally. The unit has no other combinational path to `pc`.
- `pending` rises on the edge that enters PEND and falls on the edge that loads `tgt_q` into `pc`.

## Test plan
- Reset, then 4 free cycles with no stall and no redirect -> `pc` goes 0, 4, 8, 12, 16; `taken_cnt = 0`; `if_flush` stays 0.
- At `pc = 32'h40`: `br_valid = 1`, `zero = 1`, `br_target = 32'h100` -> `if_flush = 1` that cycle; `pc = 32'h100` next; `taken_cnt = 1`. Repeating with `zero = 0` -> `pc = 32'h44`, no flush.
- Same taken branch with `id_stall = 1` -> `if_flush = 0`; `pc` holds; count unchanged. Releasing `id_stall` next cycle -> redirect accepted then.
- Taken branch to 32'h200 with `if_wait = 1` for 3 cycles -> `pending = 1` for 3 cycles with `pc` frozen; after `if_wait` drops, `pc = 32'h200` and `pending = 0`. Repeating with `rst` pulsed during PEND -> `pc = RESET_PC` and `pending = 0`.
- `jmp_valid = 1` (`jmp_target = 32'h300`) together with a taken branch to 32'h500 -> `pc = 32'h300`; `taken_cnt` increments by exactly 1. Separately, `br_target = 32'h103` -> `pc = 32'h100`.
- `CNT_W = 2`: 5 accepted redirects -> `taken_cnt = 3`. Separately, `pc = 32'hFFFF_FFFC` with free run -> `pc = 0` and `pc_plus4 = 4`.
